// File: rtl/insn_fetch.sv
// -----------------------------------------------------------------------------
// insn_fetch
// Instruction fetch stage sitting directly after the program counter. Reads
// 64-bit eBPF instruction slots from instruction memory over a req/ack
// handshake, assembles two-slot LDDW instructions, and hands decoded fields to
// the decoder with a valid/ready handshake. Issues one PC-advance pulse per
// consumed slot and abandons work on flush (taken jump / CALL / PC load).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   fetch_en          allows a new fetch to start from IDLE
//   flush             discard the current / in-flight instruction
//   pc                PC word index, sampled in IDLE only
//   fetch_adv         one-cycle pulse: PC += 1
//   mem_req/mem_addr  instruction memory read request and word address
//   mem_ack/mem_rdata read completion and 64-bit slot data
//   insn_valid/ready  decoder handshake
//   insn_opcode/dst/src/off/imm/pc/err  decoded instruction fields
// -----------------------------------------------------------------------------
module insn_fetch #(
    parameter int          ADDR_W   = 32,
    parameter logic [7:0]  LDDW_OPC = 8'h18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    output logic              fetch_adv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [7:0]        insn_opcode,
    output logic [3:0]        insn_dst,
    output logic [3:0]        insn_src,
    output logic [63:0]       insn_off,
    output logic [63:0]       insn_imm,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              insn_err
);

    typedef enum logic [2:0] {IDLE, REQ1, REQ2, DRAIN, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              adv_q;
    logic              start;
    logic              capture1;
    logic              capture2;
    logic              is_lddw;

    assign is_lddw = (mem_rdata[7:0] == LDDW_OPC);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture1   = 1'b0;
        capture2   = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en && !flush) begin
                    state_next = REQ1;
                    start      = 1'b1;
                end
            end
            REQ1, REQ2: begin
                // Flush wins over capture; an outstanding request must still
                // be drained so the memory sees a completed handshake.
                if (flush) begin
                    state_next = mem_ack ? IDLE : DRAIN;
                end else if (mem_ack) begin
                    if (state == REQ1) begin
                        capture1   = 1'b1;
                        state_next = is_lddw ? REQ2 : HOLD;
                    end else begin
                        capture2   = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            DRAIN: begin
                if (mem_ack) state_next = IDLE;
            end
            HOLD: begin
                if (flush || insn_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            adv_q       <= 1'b0;
            insn_opcode <= '0;
            insn_dst    <= '0;
            insn_src    <= '0;
            insn_off    <= '0;
            insn_imm    <= '0;
            insn_pc     <= '0;
            insn_err    <= 1'b0;
        end else begin
            state <= state_next;
            adv_q <= capture1 || capture2;
            if (start) begin
                addr_q     <= pc;
                mem_addr_q <= pc;
            end
            if (capture1) begin
                insn_opcode <= mem_rdata[7:0];
                insn_dst    <= mem_rdata[11:8];
                insn_src    <= mem_rdata[15:12];
                insn_off    <= {{48{mem_rdata[31]}}, mem_rdata[31:16]};
                insn_imm    <= {{32{mem_rdata[63]}}, mem_rdata[63:32]};
                insn_pc     <= addr_q;
                insn_err    <= 1'b0;
                // Second LDDW slot; wraps modulo 2^ADDR_W.
                if (is_lddw) mem_addr_q <= addr_q + ADDR_W'(1);
            end
            if (capture2) begin
                insn_imm[63:32] <= mem_rdata[63:32];
                insn_err        <= (mem_rdata[31:0] != 32'd0);
            end
        end
    end

    assign mem_req    = (state == REQ1) || (state == REQ2) || (state == DRAIN);
    assign mem_addr   = mem_addr_q;
    assign insn_valid = (state == HOLD);
    // A flush cycle coincides with a PC load, so the advance must not fire.
    assign fetch_adv  = adv_q && !flush;

endmodule

// File: tb/tb_insn_fetch.sv
module tb_insn_fetch;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_en;
    logic              flush;
    logic [ADDR_W-1:0] pc;
    logic              fetch_adv;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [63:0]       mem_rdata;
    logic              insn_valid;
    logic              insn_ready;
    logic [7:0]        insn_opcode;
    logic [3:0]        insn_dst;
    logic [3:0]        insn_src;
    logic [63:0]       insn_off;
    logic [63:0]       insn_imm;
    logic [ADDR_W-1:0] insn_pc;
    logic              insn_err;

    insn_fetch #(.ADDR_W(ADDR_W), .LDDW_OPC(8'h18)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .flush(flush), .pc(pc),
        .fetch_adv(fetch_adv), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .insn_valid(insn_valid),
        .insn_ready(insn_ready), .insn_opcode(insn_opcode), .insn_dst(insn_dst),
        .insn_src(insn_src), .insn_off(insn_off), .insn_imm(insn_imm),
        .insn_pc(insn_pc), .insn_err(insn_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instruction memory model: 64 slots, indexed by low address bits.
    logic [63:0]       mem [64];
    int                lat_mode = 0;   // <0: random 0..3 wait cycles
    logic [ADDR_W-1:0] ack_q [$];
    int                adv_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick_lat();
        return (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    endfunction

    // Memory responder: fixed or random wait states, checks address stability.
    initial begin
        int                cnt;
        logic              prev_wait;
        logic [ADDR_W-1:0] prev_addr;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cnt       = 0;
        prev_wait = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!mem_req || rst) begin
                cnt       = pick_lat();
                prev_wait = 1'b0;
            end else begin
                if (prev_wait) check("addr_stable", 64'(mem_addr), 64'(prev_addr));
                if (cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[5:0]];
                    ack_q.push_back(mem_addr);
                    cnt       = pick_lat();
                    prev_wait = 1'b0;
                end else begin
                    cnt--;
                    prev_wait = 1'b1;
                    prev_addr = mem_addr;
                end
            end
        end
    end

    // PC-advance pulse counter.
    initial forever begin
        @(posedge clk);
        if (fetch_adv) adv_cnt++;
    end

    // Start a fetch at address a and wait (bounded) for insn_valid.
    task automatic start_and_wait(input logic [ADDR_W-1:0] a);
        int n;
        @(negedge clk);
        pc       = a;
        fetch_en = 1'b1;
        ack_q.delete();
        adv_cnt  = 0;
        @(negedge clk);
        fetch_en = 1'b0;
        n = 0;
        while (!insn_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 64'(insn_valid), 64'(1));
    endtask

    // Full fetch: expected values derived from memory contents and eBPF rules.
    task automatic do_fetch(input logic [ADDR_W-1:0] a, input int hold);
        logic [63:0]       w1, w2, e_off, e_imm;
        logic [ADDR_W-1:0] a2;
        logic              lddw, e_err;
        w1    = mem[a[5:0]];
        a2    = a + 1;
        w2    = mem[a2[5:0]];
        lddw  = (w1[7:0] == 8'h18);
        e_off = 64'($signed(w1[31:16]));
        e_imm = lddw ? {w2[63:32], w1[63:32]} : 64'($signed(w1[63:32]));
        e_err = lddw && (w2[31:0] != 32'd0);
        start_and_wait(a);
        check("opcode", 64'(insn_opcode), 64'(w1[7:0]));
        check("dst", 64'(insn_dst), 64'(w1[11:8]));
        check("src", 64'(insn_src), 64'(w1[15:12]));
        check("off", insn_off, e_off);
        check("imm", insn_imm, e_imm);
        check("insn_pc", 64'(insn_pc), 64'(a));
        check("err", 64'(insn_err), 64'(e_err));
        check("slots_read", 64'(ack_q.size()), lddw ? 64'd2 : 64'd1);
        if (ack_q.size() > 0) check("addr1", 64'(ack_q[0]), 64'(a));
        if (lddw && ack_q.size() > 1) check("addr2", 64'(ack_q[1]), 64'(a2));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(insn_valid), 64'(1));
            check("hold_imm", insn_imm, e_imm);
            check("hold_opcode", 64'(insn_opcode), 64'(w1[7:0]));
            check("hold_no_req", 64'(mem_req), 64'(0));
        end
        insn_ready = 1'b1;
        @(negedge clk);
        insn_ready = 1'b0;
        check("valid_drop", 64'(insn_valid), 64'(0));
        check("adv_count", 64'(adv_cnt), lddw ? 64'd2 : 64'd1);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        rst = 1'b1; fetch_en = 1'b0; flush = 1'b0; pc = '0; insn_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_req", 64'(mem_req), 64'(0));
        check("rst_valid", 64'(insn_valid), 64'(0));
        check("rst_adv", 64'(fetch_adv), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_imm", insn_imm, 64'(0));
        check("rst_err", 64'(insn_err), 64'(0));

        // Simple fetch, zero wait.
        mem[5] = 64'hFFFFFFFE_8001_2107;
        do_fetch(5, 0);

        // LDDW, slot2 low word zero, then nonzero.
        mem[10] = 64'h12345678_0000_0118;
        mem[11] = 64'h9ABCDEF0_00000000;
        do_fetch(10, 0);
        mem[20] = 64'h0BADBEEF_7FFF_3218;
        mem[21] = 64'h55667788_00000001;
        do_fetch(20, 1);

        // Backpressure for 5 cycles with wait states.
        lat_mode = 2;
        mem[30] = 64'h00000010_0004_0507;
        do_fetch(30, 5);

        // LDDW wrapping the address space.
        lat_mode = 1;
        mem[63] = 64'hCAFEF00D_0000_0918;
        mem[0]  = 64'h01020304_00000000;
        do_fetch(32'hFFFF_FFFF, 0);

        // Flush during 3-cycle wait in REQ1: drained, no valid, no advance.
        lat_mode = 3;
        @(negedge clk);
        pc = 33; fetch_en = 1'b1; adv_cnt = 0;
        @(negedge clk);
        fetch_en = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("drain_req_held", 64'(mem_req), 64'(1));
        begin
            int seen_valid = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (insn_valid) seen_valid++;
            end
            check("drain_no_valid", 64'(seen_valid), 64'(0));
        end
        check("drain_no_adv", 64'(adv_cnt), 64'(0));
        check("drain_req_done", 64'(mem_req), 64'(0));
        lat_mode = 0;
        mem[40] = 64'h00000001_0000_00B7;
        do_fetch(40, 0);

        // Flush coinciding with ack.
        @(negedge clk);
        pc = 7; fetch_en = 1'b1; adv_cnt = 0;
        @(negedge clk);
        fetch_en = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flushack_idle", 64'(mem_req), 64'(0));
        repeat (3) @(negedge clk);
        check("flushack_no_valid", 64'(insn_valid), 64'(0));
        check("flushack_no_adv", 64'(adv_cnt), 64'(0));

        // Flush in HOLD with ready=1: not accepted, advance suppressed.
        mem[12] = 64'h00000002_0000_0307;
        start_and_wait(12);
        flush = 1'b1; insn_ready = 1'b1;
        #1;
        check("hold_flush_adv", 64'(fetch_adv), 64'(0));
        @(negedge clk);
        flush = 1'b0; insn_ready = 1'b0;
        check("hold_flush_valid", 64'(insn_valid), 64'(0));
        check("hold_flush_adv_cnt", 64'(adv_cnt), 64'(0));
        check("hold_flush_req", 64'(mem_req), 64'(0));

        // Reset for 2 cycles while waiting in REQ1.
        lat_mode = 10;
        @(negedge clk);
        pc = 3; fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        check("pre_rst_req", 64'(mem_req), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rst2_req", 64'(mem_req), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        adv_cnt = 0;
        @(negedge clk);
        check("rst2_valid", 64'(insn_valid), 64'(0));
        check("rst2_adv", 64'(adv_cnt), 64'(0));
        check("rst2_opcode", 64'(insn_opcode), 64'(0));
        check("rst2_addr", 64'(mem_addr), 64'(0));

        // Randomized fetches with random wait states and LDDW mix.
        lat_mode = -1;
        for (int it = 0; it < 30; it++) begin
            ra = ADDR_W'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) ra = ra | 32'hFFFF_FFC0;
            mem[ra[5:0]] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) mem[ra[5:0]][7:0] = 8'h18;
            else if (mem[ra[5:0]][7:0] == 8'h18) mem[ra[5:0]][7:0] = 8'h07;
            mem[6'(ra[5:0] + 6'd1)] = {$urandom, ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom};
            do_fetch(ra, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/insn_fetch.md
Name: insn_fetch

Overview:
Instruction fetch stage, directly downstream of the program counter. Samples the PC word index and reads 64-bit eBPF instruction slots from instruction memory over a req/ack handshake. Assembles LDDW (two-slot) instructions and presents decoded fields to the decoder with a valid/ready handshake. Pulses the PC advance once per consumed slot and supports flush on taken jumps or CALLs.

Parameters:
ADDR_W, 32, width of PC / instruction memory word address (one word = one 64-bit slot)
LDDW_OPC, 8'h18, opcode identifying the two-slot 64-bit immediate load

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
fetch_en  in  1  allows a new fetch to start from IDLE
flush  in  1  discard current/in-flight instruction (jump taken or PC load)
pc  in  ADDR_W  current PC word index, sampled in IDLE only
fetch_adv  out  1  one-cycle pulse; PC must increment by 1 (drives PC en with pc_inc=1)
mem_req  out  1  instruction memory read request
mem_addr  out  ADDR_W  read word address, stable while mem_req=1 and before ack
mem_ack  in  1  read data valid this cycle, completes request
mem_rdata  in  64  slot: [7:0] opcode, [11:8] dst, [15:12] src, [31:16] off, [63:32] imm
insn_valid  out  1  decoded instruction available
insn_ready  in  1  decoder accepts when insn_valid & insn_ready
insn_opcode  out  8  opcode
insn_dst  out  4  destination register
insn_src  out  4  source register
insn_off  out  64  off sign-extended to 64
insn_imm  out  64  imm sign-extended; LDDW: {slot2.imm, slot1.imm}
insn_pc  out  ADDR_W  address of first slot
insn_err  out  1  LDDW second slot had nonzero bits [31:0]; qualified by insn_valid

Behaviour:
- Reset (rst=1 at clk edge, any state): state=IDLE; mem_req=0, fetch_adv=0, insn_valid=0, insn_err=0, all field outputs 0, mem_addr=0. Any in-flight memory request is abandoned; memory must tolerate this.
- States: IDLE, REQ1, REQ2, DRAIN, HOLD.
- IDLE: if fetch_en & !flush -> REQ1; latch addr_q=pc; mem_req=1 and mem_addr=pc from the next cycle.
- REQ1: mem_req held high until mem_ack. On ack, capture all fields and insn_pc=addr_q, and register fetch_adv=1 for the next cycle.
  - If opcode==LDDW_OPC -> REQ2 with mem_addr=addr_q+1 (mem_req stays 1).
  - Otherwise -> HOLD; mem_req=0.
- REQ2: on ack: insn_imm[63:32]=mem_rdata[63:32]; insn_err=(mem_rdata[31:0]!=0); fetch_adv pulse next cycle; -> HOLD; mem_req=0.
- HOLD: insn_valid=1, all fields stable. On insn_ready -> IDLE; insn_valid=0 next cycle.
  - Minimum one bubble between instructions, so pc already reflects the last fetch_adv when IDLE samples it.
- Throughput: non-LDDW with zero-wait ack gives 3 cycles per instruction (IDLE, REQ1, HOLD).
- mem_addr wraps modulo 2^ADDR_W (addr_q+1 at all-ones gives 0).
- Flush (priority over insn_ready, mem_ack capture and fetch_en):
  - In IDLE: stay IDLE.
  - In HOLD: insn_valid=0 next cycle -> IDLE.
  - In REQ1/REQ2 with no ack that cycle: -> DRAIN; mem_req stays 1 until ack, data discarded -> IDLE.
  - In REQ1/REQ2 coinciding with ack: data discarded -> IDLE.
  - fetch_adv is forced 0 in any cycle where flush=1, and no pulse is issued for slots discarded by flush, so a PC load is never corrupted.
- fetch_adv pulses once per slot: exactly 1 per normal instruction, 2 per LDDW, never 2 cycles back-to-back from the same slot.
- insn_err is 0 for non-LDDW instructions.

Test Plan:
- Reset: rst=1 for 2 cycles in REQ1 with mem_req=1 -> next cycle mem_req=0, insn_valid=0, fetch_adv=0, state IDLE.
- Simple fetch: pc=5, mem_rdata=64'hFFFFFFFE_8001_2107, zero-wait ack -> insn_opcode=07, dst=1, src=2, off=64'hFFFFFFFFFFFF8001, imm=64'hFFFFFFFFFFFFFFFE, insn_pc=5, one fetch_adv pulse.
- LDDW: pc=10, slot1=64'h12345678_0000_0118, slot2=64'h9ABCDEF0_00000000 -> mem_addr 10 then 11; insn_imm=64'h9ABCDEF0_12345678, dst=1, insn_err=0, two fetch_adv pulses.
- LDDW with slot2[31:0]=1 -> insn_err=1 alongside insn_valid.
- Backpressure: insn_ready=0 for 5 cycles -> insn_valid and fields stable; no new mem_req; ready=1 -> IDLE next cycle.
- Flush during 3-cycle wait in REQ1 -> mem_req held until ack, no insn_valid, no fetch_adv; next fetch uses new pc=40. Flush in HOLD with insn_ready=1 -> instruction not accepted, insn_valid drops.
